// File: rtl/sdr_pkg.sv
// sdr_pkg: constants and types shared by the LO tuning path of the SDR.
//   M_WIDTH / M_PRESET  - PLL M count width and power-on/preset value
//                         (also used by the DDS and frequency calculator).
//   tune_state_t        - lo_tune_sequencer FSM states.
//   clamp_m()           - limits an M count to a legal [lo, hi] window.
package sdr_pkg;

    localparam int M_WIDTH  = 9;
    localparam int M_PRESET = 108;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_RESYNC    = 4'd1,
        ST_ISSUE     = 4'd2,
        ST_WAIT_BUSY = 4'd3,
        ST_WAIT_DONE = 4'd4,
        ST_WAIT_LOCK = 4'd5,
        ST_DONE      = 4'd6,
        ST_FAIL      = 4'd7,
        ST_PLL_RST   = 4'd8
    } tune_state_t;

    function automatic logic [M_WIDTH-1:0] clamp_m(
        input logic [M_WIDTH-1:0] m,
        input logic [M_WIDTH-1:0] lo,
        input logic [M_WIDTH-1:0] hi
    );
        if (m < lo) begin
            return lo;
        end else if (m > hi) begin
            return hi;
        end else begin
            return m;
        end
    endfunction

endpackage

// File: rtl/tune_target_arb.sv
// tune_target_arb: merges preset, host and quadrature-step requests into one
// registered, clamped tuning target.  Priority preset > host > step; a
// lower-priority request arriving in the same cycle as a higher one is dropped.
// Ports:
//   clk, reset           - clock, synchronous active-high reset (target -> M_PRESET)
//   preset_req           - pulse: target <= M_PRESET
//   host_req, host_m     - pulse + value: target <= clamp(host_m)
//   knob_step, knob_dir  - pulse + direction: target +/-1, saturating
//   target               - merged target M count
module tune_target_arb
    import sdr_pkg::*;
#(
    parameter int M_MIN = 1,
    parameter int M_MAX = 511
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               preset_req,
    input  logic               host_req,
    input  logic [M_WIDTH-1:0] host_m,
    input  logic               knob_step,
    input  logic               knob_dir,
    output logic [M_WIDTH-1:0] target
);

    localparam logic [M_WIDTH-1:0] MIN_M    = M_WIDTH'(M_MIN);
    localparam logic [M_WIDTH-1:0] MAX_M    = M_WIDTH'(M_MAX);
    localparam logic [M_WIDTH-1:0] PRESET_M = M_WIDTH'(M_PRESET);
    localparam logic [M_WIDTH-1:0] ONE_M    = M_WIDTH'(1);

    // Prioritised target update; the step counter saturates at the legal limits instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            target <= PRESET_M;
        end else if (preset_req) begin
            target <= PRESET_M;
        end else if (host_req) begin
            target <= clamp_m(host_m, MIN_M, MAX_M);
        end else if (knob_step) begin
            if (knob_dir) begin
                target <= (target >= MAX_M) ? MAX_M : target + ONE_M;
            end else begin
                target <= (target <= MIN_M) ? MIN_M : target - ONE_M;
            end
        end
    end

endmodule

// File: rtl/lo_tune_sequencer.sv
// lo_tune_sequencer: owns the LO tuning word and sequences DDS/PLL
// reconfiguration: update strobe, wait for busy to rise and fall, wait for
// lock, retry with a PLL reset on failure, pulse calc_start on success.
// Ports:
//   clk, reset                          - clock, synchronous active-high reset
//   preset_req, host_req, host_m,
//   knob_step, knob_dir                 - tuning requests (see tune_target_arb)
//   dds_busy, dds_locked                - DDS status
//   dds_update, dds_m, dds_pll_reset    - DDS control
//   calc_start                          - pulse after each successful lock
//   applied_m                           - last M confirmed locked (or given up on)
//   tuning_busy                         - high whenever the FSM is not idle
//   lock_fail                           - sticky lock failure, cleared by next lock
module lo_tune_sequencer
    import sdr_pkg::*;
#(
    parameter int M_MIN        = 1,
    parameter int M_MAX        = 511,
    parameter int BUSY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 500000,
    parameter int RST_CYCLES   = 16,
    parameter int MAX_RETRY    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               preset_req,
    input  logic               host_req,
    input  logic [M_WIDTH-1:0] host_m,
    input  logic               knob_step,
    input  logic               knob_dir,
    input  logic               dds_busy,
    input  logic               dds_locked,
    output logic               dds_update,
    output logic [M_WIDTH-1:0] dds_m,
    output logic               dds_pll_reset,
    output logic               calc_start,
    output logic [M_WIDTH-1:0] applied_m,
    output logic               tuning_busy,
    output logic               lock_fail
);

    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [TW-1:0]      BUSY_LIM = TW'(BUSY_TIMEOUT);
    localparam logic [TW-1:0]      LOCK_LIM = TW'(LOCK_TIMEOUT);
    localparam logic [TW-1:0]      RST_LAST = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0]      T_ONE    = TW'(1);
    localparam logic [TW-1:0]      T_ZERO   = TW'(0);
    localparam logic [RW-1:0]      R_LIM    = RW'(MAX_RETRY);
    localparam logic [RW-1:0]      R_ONE    = RW'(1);
    localparam logic [RW-1:0]      R_ZERO   = RW'(0);
    localparam logic [M_WIDTH-1:0] PRESET_M = M_WIDTH'(M_PRESET);

    tune_state_t        state;
    logic [M_WIDTH-1:0] target;
    logic [TW-1:0]      timer;
    logic [RW-1:0]      retry;

    tune_target_arb #(
        .M_MIN (M_MIN),
        .M_MAX (M_MAX)
    ) u_arb (
        .clk        (clk),
        .reset      (reset),
        .preset_req (preset_req),
        .host_req   (host_req),
        .host_m     (host_m),
        .knob_step  (knob_step),
        .knob_dir   (knob_dir),
        .target     (target)
    );

    // Sequencer FSM with registered outputs.  The update strobe and dds_m load
    // are registered on the transition into ISSUE, so dds_update is high while
    // the FSM sits in ISSUE (two cycles after a request reaches an idle FSM).
    // One shared timer serves the busy, lock and PLL-reset waits; it is held
    // at zero in every other state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_RESYNC;
            dds_m         <= PRESET_M;
            applied_m     <= PRESET_M;
            dds_update    <= 1'b0;
            dds_pll_reset <= 1'b0;
            calc_start    <= 1'b0;
            tuning_busy   <= 1'b1;
            lock_fail     <= 1'b0;
            retry         <= R_ZERO;
            timer         <= T_ZERO;
        end else begin
            dds_update  <= 1'b0;
            calc_start  <= 1'b0;
            tuning_busy <= 1'b1;
            case (state)
                ST_IDLE: begin
                    timer <= T_ZERO;
                    if ((target != applied_m) || !dds_locked) begin
                        dds_m      <= target;
                        dds_update <= 1'b1;
                        state      <= ST_ISSUE;
                    end else begin
                        tuning_busy <= 1'b0;
                    end
                end
                ST_RESYNC: begin
                    timer      <= T_ZERO;
                    dds_m      <= target;
                    dds_update <= 1'b1;
                    state      <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    timer <= T_ZERO;
                    state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (dds_busy) begin
                        timer <= T_ZERO;
                        state <= ST_WAIT_DONE;
                    end else if (timer == BUSY_LIM) begin
                        timer <= T_ZERO;
                        state <= ST_FAIL;
                    end else begin
                        timer <= timer + T_ONE;
                    end
                end
                ST_WAIT_DONE: begin
                    timer <= T_ZERO;
                    if (!dds_busy) begin
                        state <= ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (dds_locked) begin
                        timer <= T_ZERO;
                        state <= ST_DONE;
                    end else if (timer == LOCK_LIM) begin
                        timer <= T_ZERO;
                        state <= ST_FAIL;
                    end else begin
                        timer <= timer + T_ONE;
                    end
                end
                ST_DONE: begin
                    timer       <= T_ZERO;
                    applied_m   <= dds_m;
                    calc_start  <= 1'b1;
                    retry       <= R_ZERO;
                    lock_fail   <= 1'b0;
                    tuning_busy <= 1'b0;
                    state       <= ST_IDLE;
                end
                ST_FAIL: begin
                    timer <= T_ZERO;
                    if (retry == R_LIM) begin
                        // Give up: accept dds_m so IDLE does not reissue it forever.
                        lock_fail   <= 1'b1;
                        retry       <= R_ZERO;
                        applied_m   <= dds_m;
                        tuning_busy <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        retry         <= retry + R_ONE;
                        dds_pll_reset <= 1'b1;
                        state         <= ST_PLL_RST;
                    end
                end
                ST_PLL_RST: begin
                    if (timer == RST_LAST) begin
                        timer         <= T_ZERO;
                        dds_pll_reset <= 1'b0;
                        dds_m         <= target;
                        dds_update    <= 1'b1;
                        state         <= ST_ISSUE;
                    end else begin
                        timer <= timer + T_ONE;
                    end
                end
                default: begin
                    timer         <= T_ZERO;
                    dds_pll_reset <= 1'b0;
                    state         <= ST_RESYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lo_tune_sequencer.sv
// tb_lo_tune_sequencer: scoreboard bench for lo_tune_sequencer.  A behavioural
// DDS model answers each dds_update with busy for 10 cycles then lock 100
// cycles later (both can be disabled).  The expected applied M of each
// successful retune is queued when stimulus is driven and compared when
// calc_start fires.
module tb_lo_tune_sequencer;
    import sdr_pkg::*;

    localparam int BUSY_TO = 64;
    localparam int LOCK_TO = 300;
    localparam int RST_CYC = 16;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               preset_req = 1'b0;
    logic               host_req = 1'b0;
    logic [M_WIDTH-1:0] host_m = '0;
    logic               knob_step = 1'b0;
    logic               knob_dir = 1'b0;
    logic               dds_busy = 1'b0;
    logic               dds_locked = 1'b0;
    logic               dds_update;
    logic [M_WIDTH-1:0] dds_m;
    logic               dds_pll_reset;
    logic               calc_start;
    logic [M_WIDTH-1:0] applied_m;
    logic               tuning_busy;
    logic               lock_fail;

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    int exp_val;
    int calc_cnt = 0;
    int upd_cnt = 0;
    int rst_pulses = 0;
    int rst_len = 0;
    bit busy_en = 1'b1;
    bit lock_en = 1'b1;
    int phase = 0;
    int cnt = 0;

    lo_tune_sequencer #(
        .BUSY_TIMEOUT (BUSY_TO),
        .LOCK_TIMEOUT (LOCK_TO),
        .RST_CYCLES   (RST_CYC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .preset_req    (preset_req),
        .host_req      (host_req),
        .host_m        (host_m),
        .knob_step     (knob_step),
        .knob_dir      (knob_dir),
        .dds_busy      (dds_busy),
        .dds_locked    (dds_locked),
        .dds_update    (dds_update),
        .dds_m         (dds_m),
        .dds_pll_reset (dds_pll_reset),
        .calc_start    (calc_start),
        .applied_m     (applied_m),
        .tuning_busy   (tuning_busy),
        .lock_fail     (lock_fail)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int want);
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_calc(input int goal, input int budget);
        for (int i = 0; i < budget && calc_cnt < goal; i++) step();
        check_eq("calc_wait", calc_cnt, goal);
    endtask

    task automatic host_cmd(input int m);
        host_m   = M_WIDTH'(m);
        host_req = 1'b1;
        step();
        host_req = 1'b0;
    endtask

    // DDS model: busy 10 cycles after each update, then lock 100 cycles later.
    always @(negedge clk) begin
        if (dds_update) begin
            dds_locked = 1'b0;
            if (busy_en) begin
                dds_busy = 1'b1;
                phase    = 1;
                cnt      = 10;
            end else begin
                dds_busy = 1'b0;
                phase    = 0;
            end
        end else if (dds_pll_reset) begin
            dds_locked = 1'b0;
            dds_busy   = 1'b0;
            phase      = 0;
        end else if (phase == 1) begin
            cnt--;
            if (cnt == 0) begin
                dds_busy = 1'b0;
                phase    = 2;
                cnt      = 100;
            end
        end else if (phase == 2) begin
            cnt--;
            if (cnt == 0) begin
                dds_locked = lock_en;
                phase      = 0;
            end
        end
    end

    // Monitor: scoreboard compare on calc_start, PLL reset pulse length check.
    always @(negedge clk) begin
        if (dds_update) upd_cnt++;
        if (calc_start) begin
            calc_cnt++;
            if (exp_q.size() == 0) begin
                check_eq("calc_unexpected", 1, 0);
            end else begin
                exp_val = exp_q.pop_front();
                check_eq("applied_m", int'(applied_m), exp_val);
                check_eq("dds_m_at_calc", int'(dds_m), exp_val);
            end
        end
        if (dds_pll_reset) begin
            rst_len++;
        end else if (rst_len != 0) begin
            check_eq("pll_rst_len", rst_len, RST_CYC);
            rst_pulses++;
            rst_len = 0;
        end
    end

    initial begin
        int u;
        int n;
        int p;

        // 1: reset values, then the preset is programmed once.
        repeat (3) step();
        check_eq("rst_dds_update", int'(dds_update), 0);
        check_eq("rst_dds_m", int'(dds_m), 108);
        check_eq("rst_applied_m", int'(applied_m), 108);
        check_eq("rst_pll_reset", int'(dds_pll_reset), 0);
        check_eq("rst_calc_start", int'(calc_start), 0);
        check_eq("rst_lock_fail", int'(lock_fail), 0);
        check_eq("rst_tuning_busy", int'(tuning_busy), 1);
        exp_q.push_back(108);
        reset = 1'b0;
        wait_calc(1, 400);
        check_eq("t1_updates", upd_cnt, 1);
        repeat (5) step();
        check_eq("t1_idle", int'(tuning_busy), 0);

        // 2: three back-to-back quadrature increments; first launches, rest coalesce.
        exp_q.push_back(109);
        exp_q.push_back(111);
        u = upd_cnt;
        knob_dir  = 1'b1;
        knob_step = 1'b1;
        repeat (3) step();
        knob_step = 1'b0;
        wait_calc(3, 600);
        check_eq("t2_applied", int'(applied_m), 111);
        check_eq("t2_updates", upd_cnt - u, 2);

        // 3: simultaneous preset/host/quadrature step -> preset wins; host 0 clamps to 1.
        exp_q.push_back(108);
        preset_req = 1'b1;
        host_req   = 1'b1;
        host_m     = M_WIDTH'(300);
        knob_step  = 1'b1;
        knob_dir   = 1'b1;
        step();
        preset_req = 1'b0;
        host_req   = 1'b0;
        knob_step  = 1'b0;
        wait_calc(4, 400);
        exp_q.push_back(1);
        host_cmd(0);
        wait_calc(5, 400);
        check_eq("t3_dds_m_min", int'(dds_m), 1);

        // 4: quadrature-step saturation at both limits issues nothing.
        repeat (5) step();
        u = upd_cnt;
        knob_dir  = 1'b0;
        knob_step = 1'b1;
        step();
        knob_step = 1'b0;
        repeat (30) step();
        check_eq("t4_no_update_min", upd_cnt - u, 0);
        check_eq("t4_idle_min", int'(tuning_busy), 0);
        exp_q.push_back(511);
        host_cmd(511);
        wait_calc(6, 400);
        repeat (5) step();
        u = upd_cnt;
        knob_dir  = 1'b1;
        knob_step = 1'b1;
        step();
        knob_step = 1'b0;
        repeat (30) step();
        check_eq("t4_no_update_max", upd_cnt - u, 0);
        check_eq("t4_applied_max", int'(applied_m), 511);

        // 5: lock never asserts -> three PLL-reset retries, then lock_fail.
        lock_en = 1'b0;
        p = rst_pulses;
        host_cmd(200);
        for (int i = 0; i < 3000 && !lock_fail; i++) step();
        check_eq("t5_lock_fail", int'(lock_fail), 1);
        check_eq("t5_idle", int'(tuning_busy), 0);
        check_eq("t5_retries", rst_pulses - p, 3);
        check_eq("t5_applied", int'(applied_m), 200);
        lock_en = 1'b1;
        exp_q.push_back(200);
        wait_calc(7, 400);
        check_eq("t5_lock_fail_clr", int'(lock_fail), 0);

        // 6a: busy never rises -> FAIL after the busy timeout, then a retry.
        repeat (5) step();
        busy_en = 1'b0;
        u = upd_cnt;
        host_cmd(250);
        for (int i = 0; i < 10 && upd_cnt == u; i++) step();
        n = 0;
        for (int i = 0; i < 200 && !dds_pll_reset; i++) begin
            step();
            n++;
        end
        check_eq("t6_busy_window", int'(n >= BUSY_TO && n <= BUSY_TO + 4), 1);
        busy_en = 1'b1;
        exp_q.push_back(250);
        wait_calc(8, 400);
        check_eq("t6_no_lock_fail", int'(lock_fail), 0);

        // 6b: reset while waiting for lock -> strobes drop, preset reprogrammed.
        repeat (5) step();
        u = upd_cnt;
        host_cmd(300);
        for (int i = 0; i < 10 && upd_cnt == u; i++) step();
        repeat (40) step();
        reset = 1'b1;
        step();
        check_eq("t6_rst_update", int'(dds_update), 0);
        check_eq("t6_rst_pll", int'(dds_pll_reset), 0);
        check_eq("t6_rst_calc", int'(calc_start), 0);
        check_eq("t6_rst_dds_m", int'(dds_m), 108);
        reset = 1'b0;
        exp_q.push_back(108);
        wait_calc(9, 400);
        check_eq("t6_applied", int'(applied_m), 108);

        check_eq("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
